// File: rtl/pipelined_adder_tree.sv
// Pipelined adder tree: NUM_INPUTS addends per beat are reduced pairwise over LEVELS
// registered levels, optionally followed by a per-frame accumulator.
module pipelined_adder_tree #(
  parameter int ADDEND_WIDTH = 3,
  parameter int NUM_INPUTS   = 4,
  parameter int SIGNED       = 0,
  parameter int ACCUM        = 0,
  parameter int ACC_EXTRA    = 8,
  localparam int LEVELS      = $clog2(NUM_INPUTS),
  localparam int TREE_WIDTH  = ADDEND_WIDTH + LEVELS,
  localparam int DOUT_WIDTH  = TREE_WIDTH + ((ACCUM != 0) ? ACC_EXTRA : 0)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_INPUTS*ADDEND_WIDTH-1:0] in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DOUT_WIDTH-1:0]              out_data,
  output logic                               out_last
);

  if (NUM_INPUTS < 2) begin : g_param_check
    $fatal(1, "pipelined_adder_tree: NUM_INPUTS must be at least 2");
  end

  localparam bit SBIT = (SIGNED != 0);

  // Number of elements entering tree level 'level'.
  function automatic int count_at(int level);
    int c;
    c = NUM_INPUTS;
    for (int k = 0; k < level; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Handshake: a beat transfers on in_valid & in_ready, a result on out_valid & out_ready.
  // Every stage moves together on adv, and in_ready is adv itself, so out_ready reaches
  // in_ready combinationally and bubbles are held in place rather than squeezed out.
  logic                  adv;
  logic [LEVELS-1:0]     stg_valid;
  logic [LEVELS-1:0]     stg_last;
  logic [TREE_WIDTH-1:0] tree_sum;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= '0;
      stg_last  <= '0;
    end else if (adv) begin
      stg_valid[0] <= in_valid & in_ready;
      stg_last[0]  <= in_last;
      for (int j = 1; j < LEVELS; j++) begin
        stg_valid[j] <= stg_valid[j-1];
        stg_last[j]  <= stg_last[j-1];
      end
    end
  end

  genvar j, i;
  for (j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int NI = count_at(j);
    localparam int NO = count_at(j + 1);
    localparam int WI = ADDEND_WIDTH + j;
    localparam int WO = WI + 1;

    logic [WI-1:0] src [NI];
    logic [WO-1:0] sum [NO];
    logic [WO-1:0] q   [NO];

    for (i = 0; i < NI; i++) begin : g_src
      if (j == 0) begin : g_in
        assign src[i] = in_data[i*ADDEND_WIDTH +: ADDEND_WIDTH];
      end else begin : g_prev
        assign src[i] = g_lvl[j-1].q[i];
      end
    end

    // Each operand grows by one bit, so no level can overflow; an unpaired last
    // element is extended and added to zero.
    for (i = 0; i < NO; i++) begin : g_pair
      logic [WO-1:0] a;
      logic [WO-1:0] b;
      assign a = {SBIT & src[2*i][WI-1], src[2*i]};
      if (2*i + 1 < NI) begin : g_two
        assign b = {SBIT & src[2*i+1][WI-1], src[2*i+1]};
      end else begin : g_one
        assign b = '0;
      end
      assign sum[i] = a + b;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < NO; k++) q[k] <= '0;
      end else if (adv) begin
        for (int k = 0; k < NO; k++) q[k] <= sum[k];
      end
    end
  end

  assign tree_sum = g_lvl[LEVELS-1].q[0];

  if (ACCUM == 0) begin : g_direct
    assign out_valid = stg_valid[LEVELS-1];
    assign out_last  = stg_last[LEVELS-1];
    assign out_data  = tree_sum;
  end else begin : g_accum
    logic [DOUT_WIDTH-1:0] acc;
    logic [DOUT_WIDTH-1:0] sum_ext;
    logic [DOUT_WIDTH-1:0] total;
    logic [DOUT_WIDTH-1:0] data_q;
    logic                  valid_q;

    assign sum_ext = DOUT_WIDTH'($signed({SBIT & tree_sum[TREE_WIDTH-1], tree_sum}));
    assign total   = acc + sum_ext;

    // A frame's running sum lives in acc; the closing beat moves it to the output
    // register and clears acc so the next beat starts a fresh frame.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc     <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (adv) begin
        valid_q <= stg_valid[LEVELS-1] & stg_last[LEVELS-1];
        if (stg_valid[LEVELS-1]) begin
          if (stg_last[LEVELS-1]) begin
            data_q <= total;
            acc    <= '0;
          end else begin
            acc <= total;
          end
        end
      end
    end

    assign out_valid = valid_q;
    assign out_last  = valid_q;
    assign out_data  = data_q;
  end

endmodule

// File: doc/pipelined_adder_tree.md
PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 Parameter ADDEND_WIDTH, default 3: width of each addend.
REQ-002 Parameter NUM_INPUTS, default 4: addend count per beat; values below 2 SHALL stop elaboration with $fatal.
REQ-003 Parameter SIGNED, default 0: 0 means addends are unsigned and zero-extended; 1 means they are two's complement and sign-extended.
REQ-004 Parameter ACCUM, default 0: 0 means one result per beat; 1 means one result per frame, summed over beats up to in_last.
REQ-005 Parameter ACC_EXTRA, default 8: guard bits added to the accumulator when ACCUM=1.
REQ-006 Derived constants: LEVELS = clog2(NUM_INPUTS); TREE_WIDTH = ADDEND_WIDTH+LEVELS; DOUT_WIDTH = TREE_WIDTH+(ACCUM ? ACC_EXTRA : 0).
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 in_valid  input  1  in_data and in_last are valid.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 in_data  input  NUM_INPUTS*ADDEND_WIDTH  addend k is at [k*ADDEND_WIDTH +: ADDEND_WIDTH].
REQ-012 in_last  input  1  final beat of a frame; ignored when ACCUM=0.
REQ-013 out_valid  output  1  out_data and out_last are valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  DOUT_WIDTH  sum; signedness per SIGNED.
REQ-016 out_last  output  1  delayed copy of in_last (ACCUM=0); constant 1 whenever out_valid=1 (ACCUM=1).

Function
REQ-017 Transfer rule: a beat is accepted when in_valid and in_ready are both high; a result is consumed when out_valid and out_ready are both high.
REQ-018 Advance signal: adv = out_ready | ~out_valid; in_ready SHALL equal adv; this combinational path from out_ready to in_ready is allowed.
REQ-019 Pipeline structure: LEVELS registered adder levels.
  - Level j pairs element 2i with 2i+1, each extended by one bit.
  - Odd element count at a level: the last element is extended and passed through unchanged.
REQ-020 Stage behaviour: every stage has a valid bit and a last bit.
  - All stages load only when adv=1 and hold their contents when adv=0.
  - Stage 0 valid loads in_valid&in_ready.
  - Bubbles are not collapsed; the pipeline stalls as a whole.
REQ-021 Latency, ACCUM=0: a beat accepted at edge N appears on out_data/out_valid after edge N+LEVELS-1, i.e. LEVELS cycles with no stall; each stall cycle adds exactly one cycle.
REQ-022 Tree arithmetic: the tree sum is the exact sum of all addends in TREE_WIDTH bits, with no overflow possible.
REQ-023 Accumulator (ACCUM=1): acc register of DOUT_WIDTH bits, reset to 0, placed after the tree; it updates when the final tree stage is valid and adv=1.
  - last=0: acc <= acc + sum; output stays invalid.
  - last=1: output register <= acc + sum, out_valid set, acc <= 0.
  - Latency is LEVELS+1.
REQ-024 Accumulator overflow: wraps modulo 2^DOUT_WIDTH with no flag; a frame of up to 2^ACC_EXTRA beats is exact.
REQ-025 Single-beat frames: in_last=1 on a frame's only beat yields that beat's sum with out_last=1.
REQ-026 Output hold: while out_valid=1 and out_ready=0, out_data and out_last SHALL stay stable and no data SHALL be lost or duplicated.
REQ-027 Ordering: results leave in acceptance order; throughput is one beat per cycle while out_ready=1.

Reset
REQ-028 Synchronous reset: with rst high at a rising edge, all stage valid bits, out_valid, out_last and acc SHALL be 0 after that edge.
  - out_data SHALL also be 0 after that edge.
  - Data pipeline registers need not be reset.
REQ-029 Reset mid-operation: beats in flight and any partial frame are discarded.
  - in_ready SHALL be 1 in the first cycle after reset.
  - The first accepted beat after reset starts a new frame.
REQ-030 No output after reset: no out_valid pulse SHALL occur until a beat accepted after reset has traversed the pipeline.

Verification
REQ-031 Unsigned full-scale: ADDEND_WIDTH=3, NUM_INPUTS=4, SIGNED=0; in_data {7,7,7,7}, out_ready=1 -> out_data=28 (5 bits) with out_valid exactly 2 cycles after acceptance.
REQ-032 Odd input count: NUM_INPUTS=5; beat {1,2,3,4,5} -> out_data=15 after 3 cycles; a back-to-back next beat {0,0,0,0,1} gives 1 on the following cycle.
REQ-033 Signed extreme: SIGNED=1, ADDEND_WIDTH=3, NUM_INPUTS=4; {-4,-4,-4,-4} -> out_data=-16 (5'b10000); {3,-4,3,-4} -> -2.
REQ-034 Backpressure: stream 6 beats with sums 1..6 while holding out_ready=0 for 5 cycles mid-stream.
  - in_ready SHALL drop in the same cycle out_ready drops while out_valid=1.
  - Outputs SHALL be 1..6 in order, none lost or repeated, out_data stable during the stall.
REQ-035 Accumulate and reset: ACCUM=1; beats with sums 10, 20, 30 and in_last on the third -> exactly one output, 60 with out_last=1.
  - rst asserted after the second beat of a later frame -> no output from that frame.
  - The next frame, single beat 5 with in_last=1 -> output 5.
